ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16 locations).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
REQ-004 Client ports, for n = 0, 1:
- cn_req  in  1  request; held stable until granted
- cn_we  in  1  1 = write, 0 = read
- cn_addr  in  ADDR_W  target address
- cn_wdata  in  DATA_W  write data
- cn_gnt  out  1  request accepted this cycle
- cn_rvalid  out  1  read data valid, one-cycle pulse
- cn_rdata  out  DATA_W  read data
REQ-005 RAM ports:
- wr_enb  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- rd_enb  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_enb is sampled

Function
REQ-006 Write port and read port SHALL be arbitrated independently: at most one write and one read are accepted per cycle, so c0 and c1 can both be granted in the same cycle when one writes and the other reads.
REQ-007 cn_gnt SHALL be combinational from the current requests and pointers, and SHALL never be high while cn_req is low.
REQ-008 Each port SHALL keep a 1-bit round-robin pointer (wr_ptr, rd_ptr) naming the priority client.
REQ-009 Both clients contending for one port: the pointed client is granted and the pointer flips to the other client.
REQ-010 One client requesting a port: that client is granted and the pointer moves to the other client.
REQ-011 No request on a port: the pointer holds.
REQ-012 Accepted write (req and gnt at edge E0): wr_enb=1 with the registered wr_addr/wr_data for exactly the cycle after E0; otherwise wr_enb=0.
REQ-013 Accepted read at E0: rd_enb=1 with the registered rd_addr for the cycle after E0; a registered owner tag records the client.
REQ-014 At the cycle after E1 (two cycles after the request cycle), the owner's cn_rvalid SHALL pulse for one cycle with cn_rdata=rd_data; the other client's rvalid stays 0.
REQ-015 cn_rdata SHALL be 0 whenever cn_rvalid=0.
REQ-016 Back-to-back accepted reads SHALL give one rvalid per accept, in order, with no bubbles; sustained throughput is one read plus one write per cycle.
REQ-017 A losing client's request is not consumed; it is granted on a later cycle per REQ-009. Under continuous contention each client is granted every second cycle, so neither starves.
REQ-018 Write and read to the same address accepted in the same cycle: the read returns the pre-write RAM contents, unless REQ-023 applies.

Reset
REQ-019 On rst high, immediately and asynchronously, all of the following SHALL go to 0: wr_enb, rd_enb, wr_addr, wr_data, rd_addr, cn_rvalid, cn_rdata, owner tag, wr_ptr, rd_ptr.
REQ-020 While rst is high, cn_gnt SHALL be 0.
REQ-021 Reset mid-operation: reads in flight are dropped and no rvalid is produced for them after reset release.
REQ-022 The first grant after reset release goes to c0 when both clients contend.

Configuration
REQ-023 Macro RAM_ARB_RAW_BYPASS_EN:
- Defined: for a same-cycle, same-address write and read (REQ-018), the read client SHALL receive the new write data at its rvalid, not rd_data.
- Undefined: REQ-018 behaviour; no bypass logic present.

Verification
REQ-024 Reset, then c0 writes addr 3 = 0xA5, then c0 reads addr 3 -> wr_enb pulse at addr 3; c0_rvalid two cycles after the read request, c0_rdata=0xA5.
REQ-025 c0 and c1 both read (addr 1, addr 2) continuously from reset -> grants c0, c1, c0, c1...; rvalid pulses alternate, each with its own address data.
REQ-026 Same cycle: c0 writes addr 5 = 0x3C, c1 reads addr 7 (preloaded 0x11) -> both granted; wr_enb and rd_enb high together; c1_rdata=0x11.
REQ-027 Same cycle: c0 writes addr 9 = 0x77, c1 reads addr 9 (old value 0x00) -> c1_rdata=0x00 without RAM_ARB_RAW_BYPASS_EN, 0x77 with it.
REQ-028 rst asserted one cycle after a c1 read is accepted -> no c1_rvalid ever appears; rd_ptr=0; the next dual contention grants c0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-client arbiter for a simple dual-port RAM: independent round-robin on write and read ports.
// Latency: grant is combinational; RAM command is registered one cycle later; rvalid arrives two cycles after the accepted request.
// Backpressure: a losing client sees gnt=0 and must hold its request; the pointer alternates priority so neither client starves.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cN_req/we/addr/wdata - client N request (N = 0, 1); cN_gnt accepts it this cycle
//   cN_rvalid/rdata      - client N read response, one-cycle pulse; rdata is 0 when rvalid is 0
//   wr_enb/addr/data     - RAM write command
//   rd_enb/addr, rd_data - RAM read command; rd_data is valid the cycle after rd_enb is sampled
//
// Optional feature: define RAM_ARB_RAW_BYPASS_EN to forward same-cycle, same-address
// write data to the read client instead of the stale RAM contents.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,

    output logic              wr_enb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_enb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    logic              wr_ptr;      // 0: c0 has write priority, 1: c1
    logic              rd_ptr;      // 0: c0 has read priority, 1: c1
    logic              wr_req0, wr_req1, rd_req0, rd_req1;
    logic              wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
    logic              wr_acc, rd_acc;
    logic [ADDR_W-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_W-1:0] wr_sel_data;
    logic              rd_owner;    // client of the read currently on the RAM port
    logic              rsp_vld;     // RAM read data is on rd_data this cycle
    logic              rsp_owner;
    logic [DATA_W-1:0] rsp_data;

    // Requests are masked during reset so no grant can leak out.
    always_comb begin
        wr_req0 = c0_req &  c0_we & ~rst;
        wr_req1 = c1_req &  c1_we & ~rst;
        rd_req0 = c0_req & ~c0_we & ~rst;
        rd_req1 = c1_req & ~c1_we & ~rst;

        wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_ptr);
        wr_gnt1 = wr_req1 & (~wr_req0 |  wr_ptr);
        rd_gnt0 = rd_req0 & (~rd_req1 | ~rd_ptr);
        rd_gnt1 = rd_req1 & (~rd_req0 |  rd_ptr);

        wr_acc  = wr_gnt0 | wr_gnt1;
        rd_acc  = rd_gnt0 | rd_gnt1;

        wr_sel_addr = wr_gnt1 ? c1_addr  : c0_addr;
        wr_sel_data = wr_gnt1 ? c1_wdata : c0_wdata;
        rd_sel_addr = rd_gnt1 ? c1_addr  : c0_addr;
    end

    assign c0_gnt = wr_gnt0 | rd_gnt0;
    assign c1_gnt = wr_gnt1 | rd_gnt1;

    // After any grant the pointer names the other client; with no grant it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_enb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_enb    <= 1'b0;
            rd_addr   <= '0;
            rd_owner  <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr  <= wr_gnt0;
                wr_addr <= wr_sel_addr;
                wr_data <= wr_sel_data;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_gnt0;
                rd_addr  <= rd_sel_addr;
                rd_owner <= rd_gnt1;
            end
            wr_enb    <= wr_acc;
            rd_enb    <= rd_acc;
            rsp_vld   <= rd_enb;
            rsp_owner <= rd_owner;
        end
    end

`ifdef RAM_ARB_RAW_BYPASS_EN
    // A read colliding with a same-cycle write to the same address takes the
    // write data. The write data is still in wr_data one stage later.
    logic              byp_s1, byp_s2;
    logic [DATA_W-1:0] byp_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_s1  <= 1'b0;
            byp_s2  <= 1'b0;
            byp_dat <= '0;
        end else begin
            byp_s1  <= wr_acc & rd_acc & (wr_sel_addr == rd_sel_addr);
            byp_s2  <= byp_s1;
            byp_dat <= wr_data;
        end
    end

    assign rsp_data = byp_s2 ? byp_dat : rd_data;
`else
    assign rsp_data = rd_data;
`endif

    assign c0_rvalid = rsp_vld & ~rsp_owner;
    assign c1_rvalid = rsp_vld &  rsp_owner;
    assign c0_rdata  = c0_rvalid ? rsp_data : '0;
    assign c1_rdata  = c1_rvalid ? rsp_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM (read-before-write on a shared edge).
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       c0_req, c0_we, c0_gnt, c0_rvalid;
    logic [3:0] c0_addr;
    logic [7:0] c0_wdata, c0_rdata;
    logic       c1_req, c1_we, c1_gnt, c1_rvalid;
    logic [3:0] c1_addr;
    logic [7:0] c1_wdata, c1_rdata;
    logic       wr_enb, rd_enb;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    int checks   = 0;
    int failures = 0;

`ifdef RAM_ARB_RAW_BYPASS_EN
    localparam logic [7:0] RAW_EXP = 8'h77;
`else
    localparam logic [7:0] RAW_EXP = 8'h00;
`endif

    ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // RAM model: read samples the old contents when a write lands on the same edge.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (rd_enb) rd_data <= mem[rd_addr];
        if (wr_enb) mem[wr_addr] <= wr_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c0(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wd;
    endtask

    task automatic set_c1(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wd;
    endtask

    task automatic idle();
        set_c0(1'b0, 1'b0, 4'h0, 8'h00);
        set_c1(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    // Single uncontended write from c0; leaves the RAM updated on return.
    task automatic c0_write(input logic [3:0] addr, input logic [7:0] wd);
        set_c0(1'b1, 1'b1, addr, wd);
        #1 chk("wr_gnt", c0_gnt, 1);
        tick();
        idle();
        #1;
        chk("wr_enb", wr_enb, 1);
        chk("wr_addr", wr_addr, addr);
        chk("wr_data", wr_data, wd);
        tick();
    endtask

    // Single uncontended read from c0; response expected two cycles after the request.
    task automatic c0_read(input logic [3:0] addr, input logic [7:0] exp);
        set_c0(1'b1, 1'b0, addr, 8'h00);
        #1 chk("rd_gnt", c0_gnt, 1);
        tick();
        idle();
        #1;
        chk("rd_enb", rd_enb, 1);
        chk("rd_addr", rd_addr, addr);
        chk("rv_early", c0_rvalid, 0);
        tick();
        chk("c0_rvalid", c0_rvalid, 1);
        chk("c0_rdata", c0_rdata, exp);
        chk("c1_rvalid_q", c1_rvalid, 0);
        tick();
        chk("c0_rvalid_end", c0_rvalid, 0);
        chk("c0_rdata_zero", c0_rdata, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        // Reset state; grants stay low under reset even with requests present.
        chk("rst_wr_enb", wr_enb, 0);
        chk("rst_rd_enb", rd_enb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
        chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
        set_c0(1'b1, 1'b0, 4'h1, 8'h00);
        set_c1(1'b1, 1'b1, 4'h2, 8'h00);
        #1 chk("rst_gnt", {c0_gnt, c1_gnt}, 0);
        idle();
        tick();
        rst = 1'b0;

        // Write then read back through c0.
        c0_write(4'h3, 8'hA5);
        c0_read(4'h3, 8'hA5);

        // Preload for later scenarios.
        c0_write(4'h1, 8'h5A);
        c0_write(4'h2, 8'hC3);
        c0_write(4'h7, 8'h11);
        c0_write(4'h9, 8'h00);

        // Continuous dual read contention from reset: grants alternate, responses follow in order.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                set_c0(1'b1, 1'b0, 4'h1, 8'h00);
                set_c1(1'b1, 1'b0, 4'h2, 8'h00);
            end else begin
                idle();
            end
            #1;
            if (i < 4) begin
                chk("rr_c0_gnt", c0_gnt, (i % 2 == 0));
                chk("rr_c1_gnt", c1_gnt, (i % 2 == 1));
            end
            if (i >= 2) begin
                chk("rr_c0_rvalid", c0_rvalid, (i % 2 == 0));
                chk("rr_c1_rvalid", c1_rvalid, (i % 2 == 1));
                if (i % 2 == 0) chk("rr_c0_rdata", c0_rdata, 8'h5A);
                else            chk("rr_c1_rdata", c1_rdata, 8'hC3);
            end
            tick();
        end

        // Concurrent write (c0) and read (c1) to different addresses.
        set_c0(1'b1, 1'b1, 4'h5, 8'h3C);
        set_c1(1'b1, 1'b0, 4'h7, 8'h00);
        #1 chk("par_gnt", {c0_gnt, c1_gnt}, 2'b11);
        tick();
        idle();
        #1;
        chk("par_enb", {wr_enb, rd_enb}, 2'b11);
        chk("par_wr_addr", wr_addr, 4'h5);
        chk("par_rd_addr", rd_addr, 4'h7);
        tick();
        chk("par_c1_rvalid", c1_rvalid, 1);
        chk("par_c1_rdata", c1_rdata, 8'h11);
        chk("par_c0_rvalid", c0_rvalid, 0);
        tick();
        chk("par_rvalid_end", c1_rvalid, 0);
        chk("par_rdata_zero", c1_rdata, 0);

        // Same-cycle write and read to one address.
        set_c0(1'b1, 1'b1, 4'h9, 8'h77);
        set_c1(1'b1, 1'b0, 4'h9, 8'h00);
        #1 chk("raw_gnt", {c0_gnt, c1_gnt}, 2'b11);
        tick();
        idle();
        tick();
        chk("raw_c1_rvalid", c1_rvalid, 1);
        chk("raw_c1_rdata", c1_rdata, RAW_EXP);
        tick();
        c0_read(4'h9, 8'h77);

        // Reset one cycle after a c1 read is accepted: the read is dropped.
        set_c1(1'b1, 1'b0, 4'h2, 8'h00);
        #1 chk("drop_gnt", c1_gnt, 1);
        tick();
        idle();
        #1 chk("drop_rd_enb_pre", rd_enb, 1);
        rst = 1'b1;
        #1;
        chk("drop_rd_enb", rd_enb, 0);
        chk("drop_rd_addr", rd_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("drop_no_rvalid", {c0_rvalid, c1_rvalid}, 0);
            tick();
        end
        set_c0(1'b1, 1'b0, 4'h1, 8'h00);
        set_c1(1'b1, 1'b0, 4'h2, 8'h00);
        #1 chk("drop_first_gnt", {c0_gnt, c1_gnt}, 2'b10);
        tick();
        idle();
        tick();
        tick();

        // Move both pointers to c1, reset, and confirm c0 wins first on both ports.
        set_c0(1'b1, 1'b0, 4'h0, 8'h00);
        tick();
        set_c0(1'b1, 1'b1, 4'h0, 8'h00);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_c0(1'b1, 1'b1, 4'h4, 8'h44);
        set_c1(1'b1, 1'b1, 4'h6, 8'h66);
        #1 chk("ptr_wr_first", {c0_gnt, c1_gnt}, 2'b10);
        tick();
        chk("ptr_wr_second", {c0_gnt, c1_gnt}, 2'b01);
        chk("ptr_wr_addr0", wr_addr, 4'h4);
        chk("ptr_wr_data0", wr_data, 8'h44);
        tick();
        chk("ptr_wr_third", {c0_gnt, c1_gnt}, 2'b10);
        chk("ptr_wr_addr1", wr_addr, 4'h6);
        chk("ptr_wr_data1", wr_data, 8'h66);
        set_c0(1'b1, 1'b0, 4'h4, 8'h00);
        set_c1(1'b1, 1'b0, 4'h6, 8'h00);
        #1 chk("ptr_rd_first", {c0_gnt, c1_gnt}, 2'b10);
        tick();
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
